cpu7_ifu_fcl: RTL and testbench

Fetch control logic for the cpu7 IFU. Sequences the fetch PC datapath: drives the one-hot-low pc_bf mux selects, the instruction-request handshake and cancel, and the decode-valid qualifier. Tracks in-flight fetch responses so that stale responses after a branch or exception redirect are dropped. Holds the redirect target until the fetch port can accept it. Sits between the memory fetch port, the EXU redirect/stall sources and the fetch datapath.

---
 rtl/cpu7_ifu_pkg.sv | 30 +++
 rtl/cpu7_ifu_fcl_cnt.sv | 31 +++
 rtl/cpu7_ifu_fcl.sv | 200 ++++++++++++++++++++
 tb/tb_cpu7_ifu_fcl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu7_ifu_pkg.sv
// Shared IFU types: fetch-control states, pc_bf select indices, defaults.
// Also provides the GRLEN default width when the core build leaves it unset.
`ifndef GRLEN
`define GRLEN 32
`endif

package cpu7_ifu_pkg;

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } fcl_state_e;

   localparam logic [1:0] SEL_INIT  = 2'd0;
   localparam logic [1:0] SEL_OLD   = 2'd1;
   localparam logic [1:0] SEL_PCINC = 2'd2;
   localparam logic [1:0] SEL_REDIR = 2'd3;

   localparam int MAX_OUTSTANDING_DEF = 2;

   // Active-low one-hot select vector, bit order {redir, pcinc, old, init}.
   function automatic logic [3:0] sel_low(input logic [1:0] idx);
      logic [3:0] v;
      v      = 4'hf;
      v[idx] = 1'b0;
      return v;
   endfunction

endpackage

// File: rtl/cpu7_ifu_fcl_cnt.sv
// Up/down counter with synchronous load; load wins over inc/dec.
// Used for the in-flight fetch count and the stale-response drop count.
module cpu7_ifu_fcl_cnt #(
   parameter int W = 2
) (
   input  logic         i_clock,
   input  logic         i_reset,
   input  logic         i_inc,
   input  logic         i_dec,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_inc && !i_dec) begin
         r_cnt <= r_cnt + W'(1);
      end else if (i_dec && !i_inc) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/cpu7_ifu_fcl.sv
// cpu7 IFU fetch control: pc_bf selects, fetch handshake, stale-drop drain.
// Optional perf counters enabled by defining CPU7_IFU_FCL_PERF_EN.
module cpu7_ifu_fcl
   import cpu7_ifu_pkg::*;
#(
   parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
   parameter int CNTW            = 2
) (
   input  logic              i_clock,
   input  logic              i_reset,
   output logic              o_inst_req,
   input  logic              i_inst_addr_ok,
   input  logic              i_inst_valid,
   output logic              o_inst_cancel,
   input  logic              i_br_taken,
   input  logic [31:0]       i_br_target,
   input  logic              i_exu_ifu_except,
   input  logic [`GRLEN-1:0] i_exu_ifu_eentry,
   input  logic              i_exu_ifu_stall_req,
   output logic              o_fcl_fdp_pcbf_sel_init_l,
   output logic              o_fcl_fdp_pcbf_sel_old_l,
   output logic              o_fcl_fdp_pcbf_sel_pcinc_l,
   output logic              o_fcl_fdp_pcbf_sel_redir_l,
   output logic [31:0]       o_fcl_fdp_redir_pc,
   output logic              o_fcl_fdp_dec_valid,
`ifdef CPU7_IFU_FCL_PERF_EN
   output logic [31:0]       o_fcl_perf_fetch,
   output logic [31:0]       o_fcl_perf_bubble,
`endif
   output logic [CNTW-1:0]   o_fcl_dbg_outstanding
);

   fcl_state_e      r_state;
   fcl_state_e      w_state_nxt;
   logic            r_pend;
   logic            w_pend_nxt;
   logic [31:0]     r_redir_pc;

   logic [CNTW-1:0] w_out;
   logic [CNTW-1:0] w_drop;
   logic [CNTW-1:0] w_drop_val;
   logic            w_redir;
   logic            w_vld;
   logic            w_room;
   logic            w_acc;

   logic            w_req;
   logic            w_cancel;
   logic            w_dec;
   logic [1:0]      w_sel;
   logic            w_drop_ld;
   logic            w_drop_dec;
   logic            w_redir_ld;
   logic [3:0]      w_sel_l;

   assign w_redir    = i_exu_ifu_except | i_br_taken;
   // A response with nothing in flight is a protocol error and is ignored.
   assign w_vld      = i_inst_valid & (w_out != '0);
   assign w_room     = w_out < CNTW'(MAX_OUTSTANDING);
   assign w_drop_val = w_out - CNTW'(w_vld);
   assign w_acc      = w_req & i_inst_addr_ok;

   always_comb begin
      w_state_nxt = r_state;
      w_pend_nxt  = r_pend;
      w_req       = 1'b0;
      w_cancel    = 1'b0;
      w_dec       = 1'b0;
      w_sel       = SEL_OLD;
      w_drop_ld   = 1'b0;
      w_drop_dec  = 1'b0;
      w_redir_ld  = 1'b0;
      unique case (r_state)
         INIT: begin
            w_sel       = SEL_INIT;
            w_state_nxt = RUN;
            w_pend_nxt  = 1'b0;
         end
         RUN, DRAIN: begin
            if (r_state == DRAIN) begin
               w_drop_dec = w_vld;
            end
            if (w_redir) begin
               w_cancel   = 1'b1;
               w_drop_ld  = 1'b1;
               w_redir_ld = 1'b1;
               if (w_drop_val == '0) begin
                  w_state_nxt = RUN;
                  w_pend_nxt  = 1'b1;
               end else begin
                  w_state_nxt = DRAIN;
                  w_pend_nxt  = 1'b0;
               end
            end else if (r_state == DRAIN) begin
               if (w_vld && w_drop == CNTW'(1)) begin
                  w_state_nxt = RUN;
                  w_pend_nxt  = 1'b1;
               end
            end else begin
               w_req = ~i_exu_ifu_stall_req & w_room;
               w_dec = w_vld & ~i_exu_ifu_stall_req;
               if (r_pend) begin
                  w_sel = SEL_REDIR;
                  if (w_req && i_inst_addr_ok) begin
                     w_pend_nxt = 1'b0;
                  end
               end else if (w_req && i_inst_addr_ok) begin
                  w_sel = SEL_PCINC;
               end
            end
         end
         default: begin
            w_state_nxt = INIT;
            w_pend_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= INIT;
         r_pend     <= 1'b0;
         r_redir_pc <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pend  <= w_pend_nxt;
         if (w_redir_ld) begin
            r_redir_pc <= i_exu_ifu_except ?
                          i_exu_ifu_eentry[31:0] : i_br_target;
         end
      end
   end

   cpu7_ifu_fcl_cnt #(.W(CNTW)) u_out_cnt (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .i_inc      (w_acc),
      .i_dec      (w_vld),
      .i_load     (1'b0),
      .i_load_val ('0),
      .o_cnt      (w_out)
   );

   cpu7_ifu_fcl_cnt #(.W(CNTW)) u_drop_cnt (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .i_inc      (1'b0),
      .i_dec      (w_drop_dec),
      .i_load     (w_drop_ld),
      .i_load_val (w_drop_val),
      .o_cnt      (w_drop)
   );

   assign w_sel_l = sel_low(w_sel);

   assign o_inst_req                 = w_req;
   assign o_inst_cancel              = w_cancel;
   assign o_fcl_fdp_dec_valid        = w_dec;
   assign o_fcl_fdp_pcbf_sel_init_l  = w_sel_l[SEL_INIT];
   assign o_fcl_fdp_pcbf_sel_old_l   = w_sel_l[SEL_OLD];
   assign o_fcl_fdp_pcbf_sel_pcinc_l = w_sel_l[SEL_PCINC];
   assign o_fcl_fdp_pcbf_sel_redir_l = w_sel_l[SEL_REDIR];
   assign o_fcl_fdp_redir_pc         = r_redir_pc;
   assign o_fcl_dbg_outstanding      = w_out;

`ifdef CPU7_IFU_FCL_PERF_EN
   logic [31:0] r_perf_fetch;
   logic [31:0] r_perf_bubble;
   logic        w_bubble;

   assign w_bubble = (r_state == DRAIN) |
                     ((r_state == RUN) & i_exu_ifu_stall_req);

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_perf_fetch  <= '0;
         r_perf_bubble <= '0;
      end else begin
         if (w_dec) begin
            r_perf_fetch <= r_perf_fetch + 32'd1;
         end
         if (w_bubble) begin
            r_perf_bubble <= r_perf_bubble + 32'd1;
         end
      end
   end

   assign o_fcl_perf_fetch  = r_perf_fetch;
   assign o_fcl_perf_bubble = r_perf_bubble;
`endif

`ifndef SYNTHESIS
   always_ff @(posedge i_clock) begin
      if (!i_reset && i_inst_valid) begin
         assert (w_out != '0);
      end
   end
`endif

endmodule

// File: tb/tb_cpu7_ifu_fcl.sv
// Bench for cpu7_ifu_fcl: directed vector table, hand sequences and a
// randomized run against a transaction-level reference model.
module tb_cpu7_ifu_fcl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req, ok, vld, cancel;
   logic        br, exc, stall;
   logic [31:0] tgt, ent;
   logic        s_init, s_old, s_pcinc, s_redir;
   logic [31:0] rpc;
   logic        dec;
   logic [1:0]  outst;
`ifdef CPU7_IFU_FCL_PERF_EN
   logic [31:0] perf_fetch, perf_bubble;
`endif

   int n_tot = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   cpu7_ifu_fcl dut (
      .i_clock                    (clk),
      .i_reset                    (rst),
      .o_inst_req                 (req),
      .i_inst_addr_ok             (ok),
      .i_inst_valid               (vld),
      .o_inst_cancel              (cancel),
      .i_br_taken                 (br),
      .i_br_target                (tgt),
      .i_exu_ifu_except           (exc),
      .i_exu_ifu_eentry           (ent),
      .i_exu_ifu_stall_req        (stall),
      .o_fcl_fdp_pcbf_sel_init_l  (s_init),
      .o_fcl_fdp_pcbf_sel_old_l   (s_old),
      .o_fcl_fdp_pcbf_sel_pcinc_l (s_pcinc),
      .o_fcl_fdp_pcbf_sel_redir_l (s_redir),
      .o_fcl_fdp_redir_pc         (rpc),
      .o_fcl_fdp_dec_valid        (dec),
`ifdef CPU7_IFU_FCL_PERF_EN
      .o_fcl_perf_fetch           (perf_fetch),
      .o_fcl_perf_bubble          (perf_bubble),
`endif
      .o_fcl_dbg_outstanding      (outst)
   );

   // Select vector order {redir, pcinc, old, init}, active low.
   localparam logic [3:0] L_INIT  = 4'b1110;
   localparam logic [3:0] L_OLD   = 4'b1101;
   localparam logic [3:0] L_PCINC = 4'b1011;
   localparam logic [3:0] L_REDIR = 4'b0111;

   function automatic logic [3:0] sel_now();
      return {s_redir, s_pcinc, s_old, s_init};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tot++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic b, input logic x, input logic s,
                        input logic k, input logic v,
                        input logic [31:0] t, input logic [31:0] e);
      br = b; exc = x; stall = s; ok = k; vld = v; tgt = t; ent = e;
   endtask

   typedef struct {
      logic        br, exc, stall, ok, vld;
      logic [31:0] tgt, ent;
      logic        req, cancel, dec;
      logic [3:0]  sel;
      logic [1:0]  out;
      logic [31:0] rpc;
   } vec_t;

   vec_t tv[21];

   function automatic vec_t mk(
      input logic b, input logic x, input logic s, input logic k,
      input logic v, input logic [31:0] t, input logic [31:0] e,
      input logic rq, input logic cn, input logic dv,
      input logic [3:0] sl, input logic [1:0] o, input logic [31:0] pc);
      vec_t r;
      r.br = b; r.exc = x; r.stall = s; r.ok = k; r.vld = v;
      r.tgt = t; r.ent = e;
      r.req = rq; r.cancel = cn; r.dec = dv;
      r.sel = sl; r.out = o; r.rpc = pc;
      return r;
   endfunction

   // Reference model: counts of in-flight and stale responses plus flags.
   int          m_out, m_drop;
   bit          m_init, m_drain, m_wait;
   logic [31:0] m_rpc;

   task automatic model_reset();
      m_out = 0; m_drop = 0;
      m_init = 1; m_drain = 0; m_wait = 0;
      m_rpc = 0;
   endtask

   task automatic model_cycle(output logic e_req, output logic e_can,
                              output logic e_dec, output logic [3:0] e_sel);
      bit v_ok;
      bit acc;
      v_ok  = vld && (m_out > 0);
      e_req = 0; e_can = 0; e_dec = 0; e_sel = L_OLD;
      if (m_init) begin
         e_sel  = L_INIT;
         m_init = 0;
      end else if (br || exc) begin
         e_can = 1;
         m_rpc = exc ? ent : tgt;
         if (v_ok) m_out--;
         if (m_out == 0) begin
            m_drain = 0; m_wait = 1;
         end else begin
            m_drain = 1; m_wait = 0; m_drop = m_out;
         end
      end else if (m_drain) begin
         if (v_ok) begin
            m_out--; m_drop--;
            if (m_drop == 0) begin
               m_drain = 0; m_wait = 1;
            end
         end
      end else begin
         e_req = !stall && (m_out < 2);
         acc   = e_req && ok;
         e_dec = v_ok && !stall;
         if (m_wait) e_sel = L_REDIR;
         else if (acc) e_sel = L_PCINC;
         if (acc) m_out++;
         if (v_ok) m_out--;
         if (acc) m_wait = 0;
      end
   endtask

   initial begin
      logic        e_req, e_can, e_dec;
      logic [3:0]  e_sel;
      logic [31:0] e_rpc;
      logic [1:0]  e_out;

      tv[0]  = mk(0,0,0,1,0, 0,0, 0,0,0, L_INIT , 0, 0);
      tv[1]  = mk(0,0,0,1,0, 0,0, 1,0,0, L_PCINC, 0, 0);
      tv[2]  = mk(0,0,0,1,0, 0,0, 1,0,0, L_PCINC, 1, 0);
      tv[3]  = mk(0,0,0,1,0, 0,0, 0,0,0, L_OLD  , 2, 0);
      tv[4]  = mk(0,0,0,1,1, 0,0, 0,0,1, L_OLD  , 2, 0);
      tv[5]  = mk(0,0,0,1,0, 0,0, 1,0,0, L_PCINC, 1, 0);
      tv[6]  = mk(1,0,0,1,0, 32'h1c000100,0, 0,1,0, L_OLD, 2, 0);
      tv[7]  = mk(0,0,0,1,1, 0,0, 0,0,0, L_OLD  , 2, 32'h1c000100);
      tv[8]  = mk(0,0,0,1,0, 0,0, 0,0,0, L_OLD  , 1, 32'h1c000100);
      tv[9]  = mk(0,0,0,1,1, 0,0, 0,0,0, L_OLD  , 1, 32'h1c000100);
      tv[10] = mk(0,0,0,0,0, 0,0, 1,0,0, L_REDIR, 0, 32'h1c000100);
      tv[11] = mk(0,0,0,1,0, 0,0, 1,0,0, L_REDIR, 0, 32'h1c000100);
      tv[12] = mk(0,0,0,0,1, 0,0, 1,0,1, L_OLD  , 1, 32'h1c000100);
      tv[13] = mk(1,0,0,1,0, 32'h1c000100,0, 0,1,0, L_OLD, 0,
                  32'h1c000100);
      tv[14] = mk(0,0,0,1,0, 0,0, 1,0,0, L_REDIR, 0, 32'h1c000100);
      tv[15] = mk(1,1,0,1,1, 32'h1c000400,32'h1c008000, 0,1,0, L_OLD, 1,
                  32'h1c000100);
      tv[16] = mk(0,0,1,0,0, 0,0, 0,0,0, L_REDIR, 0, 32'h1c008000);
      tv[17] = mk(0,0,0,1,0, 0,0, 1,0,0, L_REDIR, 0, 32'h1c008000);
      tv[18] = mk(0,0,0,1,0, 0,0, 1,0,0, L_PCINC, 1, 32'h1c008000);
      tv[19] = mk(0,0,1,1,1, 0,0, 0,0,0, L_OLD  , 2, 32'h1c008000);
      tv[20] = mk(0,0,0,0,1, 0,0, 1,0,1, L_OLD  , 1, 32'h1c008000);

      // Reset values
      drive(0,0,0,0,0,0,0);
      rst = 1'b1;
      @(negedge clk);
      chk("rst.sel", 32'(sel_now()), 32'(L_INIT));
      chk("rst.req", 32'(req), 0);
      chk("rst.cancel", 32'(cancel), 0);
      chk("rst.dec", 32'(dec), 0);
      chk("rst.rpc", rpc, 0);
      chk("rst.out", 32'(outst), 0);
      @(posedge clk); #1 rst = 1'b0;

      for (int i = 0; i < 21; i++) begin
         drive(tv[i].br, tv[i].exc, tv[i].stall, tv[i].ok, tv[i].vld,
               tv[i].tgt, tv[i].ent);
         @(negedge clk);
         chk($sformatf("v%0d.req", i), 32'(req), 32'(tv[i].req));
         chk($sformatf("v%0d.cancel", i), 32'(cancel), 32'(tv[i].cancel));
         chk($sformatf("v%0d.dec", i), 32'(dec), 32'(tv[i].dec));
         chk($sformatf("v%0d.sel", i), 32'(sel_now()), 32'(tv[i].sel));
         chk($sformatf("v%0d.out", i), 32'(outst), 32'(tv[i].out));
         chk($sformatf("v%0d.rpc", i), rpc, tv[i].rpc);
         @(posedge clk); #1;
      end

      // Reset asserted mid-drain
      drive(0,0,0,1,0,0,0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      drive(1,0,0,1,0,32'h1c000500,0);
      @(negedge clk);
      chk("md.cancel", 32'(cancel), 1);
      @(posedge clk); #1;
      drive(0,0,0,1,0,0,0);
      @(negedge clk);
      chk("md.drain_req", 32'(req), 0);
      chk("md.drain_sel", 32'(sel_now()), 32'(L_OLD));
      chk("md.drain_out", 32'(outst), 2);
      #2 rst = 1'b1;
      #1;
      chk("md.rst_sel", 32'(sel_now()), 32'(L_INIT));
      chk("md.rst_req", 32'(req), 0);
      chk("md.rst_out", 32'(outst), 0);
      chk("md.rst_rpc", rpc, 0);
      chk("md.rst_dec", 32'(dec), 0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("md.init_sel", 32'(sel_now()), 32'(L_INIT));
      chk("md.init_req", 32'(req), 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("md.run_req", 32'(req), 1);
      chk("md.run_sel", 32'(sel_now()), 32'(L_PCINC));

      // Randomized run against the reference model
      drive(0,0,0,0,0,0,0);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         drive($urandom_range(0, 99) < 6,
               $urandom_range(0, 99) < 3,
               $urandom_range(0, 99) < 15,
               $urandom_range(0, 99) < 60,
               (m_out > 0) && ($urandom_range(0, 99) < 50),
               $urandom, $urandom);
         @(negedge clk);
         e_rpc = m_rpc;
         e_out = 2'(m_out);
         model_cycle(e_req, e_can, e_dec, e_sel);
         chk($sformatf("r%0d.req", c), 32'(req), 32'(e_req));
         chk($sformatf("r%0d.cancel", c), 32'(cancel), 32'(e_can));
         chk($sformatf("r%0d.dec", c), 32'(dec), 32'(e_dec));
         chk($sformatf("r%0d.sel", c), 32'(sel_now()), 32'(e_sel));
         chk($sformatf("r%0d.out", c), 32'(outst), 32'(e_out));
         chk($sformatf("r%0d.rpc", c), rpc, e_rpc);
         @(posedge clk); #1;
      end

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
